// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, data width and the issuer FSM encoding.
// Used by the command issuer and by the ALU it drives.
package alu_pkg;

  localparam int ALU_W = 16;
  localparam int OP_W  = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_SHL = 3'd5;
  localparam logic [OP_W-1:0] OP_SHR = 3'd6;
  localparam logic [OP_W-1:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } issuer_state_t;

endpackage

// File: rtl/alu_cmd_issuer_enable_hold.sv
// Clock-gate enable generator for the ALU: enable is high while busy and for
// HOLD_CYCLES cycles after load, then drops. Output is registered (glitch-free).
module alu_enable_hold #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic load,
  output logic enable
);

  localparam int CNT_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_enable;

  // busy/load describe the next cycle, so r_enable lines up with the work itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_enable <= 1'b0;
    end else if (load) begin
      r_cnt    <= HOLD_V;
      r_enable <= (HOLD_V != '0);
    end else if (busy) begin
      r_cnt    <= HOLD_V;
      r_enable <= 1'b1;
    end else begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
      r_enable <= (r_cnt > CNT_ONE);
    end
  end

  assign enable = r_enable;

endmodule

// File: rtl/alu_cmd_issuer.sv
// Initiator for the 16-bit clock-gated ALU: issue one tagged command, capture the
// registered result, return a tagged response. Optional counters: ALU_ISSUER_STATS_EN.
import alu_pkg::*;

module alu_cmd_issuer #(
  parameter int TAG_W       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [ALU_W-1:0] cmd_a,
  input  logic [ALU_W-1:0] cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  output logic             alu_enable,
  input  logic [ALU_W-1:0] alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ALU_W-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [1:0]       dbg_state
`ifdef ALU_ISSUER_STATS_EN
  ,
  output logic [31:0]      stat_ops,
  output logic [31:0]      stat_gated_cycles
`endif
);

  // Both channels: a transfer happens on a rising edge where valid && ready;
  // the sender holds its fields stable from raising valid until that edge.

  issuer_state_t    r_state;
  logic             r_cmd_ready;
  logic [ALU_W-1:0] r_alu_a;
  logic [ALU_W-1:0] r_alu_b;
  logic [OP_W-1:0]  r_alu_op;
  logic [TAG_W-1:0] r_tag;
  logic             r_rsp_valid;
  logic [ALU_W-1:0] r_rsp_result;
  logic             r_rsp_carry;
  logic             r_rsp_zero;
  logic [TAG_W-1:0] r_rsp_tag;

  logic w_accept;
  logic w_rsp_hs;
  logic w_busy_next;
  logic w_load_hold;
  logic w_alu_enable;

  assign w_accept    = (r_state == ST_IDLE) && cmd_valid && r_cmd_ready;
  assign w_rsp_hs    = (r_state == ST_RESP) && rsp_ready;
  assign w_busy_next = w_accept || (r_state == ST_ISSUE);
  assign w_load_hold = (r_state == ST_CAPTURE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cmd_ready  <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_tag        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_rsp_tag    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_alu_a     <= cmd_a;
            r_alu_b     <= cmd_b;
            r_alu_op    <= cmd_op;
            r_tag       <= cmd_tag;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_ISSUE;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // The ALU zero flag lags its result by a cycle, so zero is derived here.
          r_rsp_result <= alu_result;
          r_rsp_carry  <= alu_carry;
          r_rsp_zero   <= (alu_result == '0);
          r_rsp_tag    <= r_tag;
          r_rsp_valid  <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  alu_enable_hold #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_enable_hold (
    .clk   (clk),
    .rst   (rst),
    .busy  (w_busy_next),
    .load  (w_load_hold),
    .enable(w_alu_enable)
  );

  assign cmd_ready  = r_cmd_ready;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign alu_enable = w_alu_enable;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_tag    = r_rsp_tag;
  assign dbg_state  = r_state;

`ifdef ALU_ISSUER_STATS_EN
  logic [31:0] r_stat_ops;
  logic [31:0] r_stat_gated;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_ops   <= '0;
      r_stat_gated <= '0;
    end else begin
      if (w_rsp_hs && (r_stat_ops != '1)) begin
        r_stat_ops <= r_stat_ops + 32'd1;
      end
      if (!w_alu_enable && (r_stat_gated != '1)) begin
        r_stat_gated <= r_stat_gated + 32'd1;
      end
    end
  end

  assign stat_ops          = r_stat_ops;
  assign stat_gated_cycles = r_stat_gated;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: behavioural clock-gated ALU, directed plus random
// commands, expected-response queue checked by an independent monitor.
`timescale 1ns/1ps
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int TAG_W = 4;
  localparam int HOLD  = 2;
  localparam int EXP_W = TAG_W + 2 + 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = '0;
  logic [15:0]      cmd_a = '0;
  logic [15:0]      cmd_b = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [15:0]      alu_a, alu_b;
  logic [2:0]       alu_op;
  logic             alu_enable;
  logic [15:0]      alu_result = '0;
  logic             alu_carry = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [15:0]      rsp_result;
  logic             rsp_carry, rsp_zero;
  logic [TAG_W-1:0] rsp_tag;
  logic [1:0]       dbg_state;
`ifdef ALU_ISSUER_STATS_EN
  logic [31:0]      stat_ops, stat_gated_cycles;
`endif

  alu_cmd_issuer #(.TAG_W(TAG_W), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_enable(alu_enable),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
    .dbg_state(dbg_state)
`ifdef ALU_ISSUER_STATS_EN
    , .stat_ops(stat_ops), .stat_gated_cycles(stat_gated_cycles)
`endif
  );

  // ---------------- clock / cycle count ----------------
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int               acc_q[$];
  int               checks = 0;
  int               fails = 0;
  int               ready_mode = 1;  // 0 low, 1 high, 2 random

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ALU arithmetic: {carry, result}. Carry is add carry-out or sub borrow.
  function automatic logic [16:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    int unsigned ua = a;
    int unsigned ub = b;
    int unsigned sh = b % 16;
    case (op)
      OP_ADD:  alu_ref = 17'(ua + ub);
      OP_SUB:  alu_ref = {(ua < ub), 16'(ua - ub)};
      OP_AND:  alu_ref = {1'b0, a & b};
      OP_OR:   alu_ref = {1'b0, a | b};
      OP_XOR:  alu_ref = {1'b0, a ^ b};
      OP_SHL:  alu_ref = {1'b0, 16'(ua << sh)};
      OP_SHR:  alu_ref = {1'b0, 16'(ua >> sh)};
      default: alu_ref = {1'b0, 16'(ua * ub)};
    endcase
  endfunction

  // Behavioural registered ALU: only advances while its clock is enabled.
  always @(posedge clk) begin
    if (rst) {alu_carry, alu_result} <= 17'h0;
    else if (alu_enable) {alu_carry, alu_result} <= alu_ref(alu_op, alu_a, alu_b);
  end

  // ---------------- rsp_ready driver ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- command driver ----------------
  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [TAG_W-1:0] tag, input logic [15:0] e_res,
                      input logic e_c, input bit keep, output int acc);
    int waited = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
    acc = -1;
    @(negedge clk);
    while (!cmd_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (cmd_ready) begin
      exp_q.push_back({tag, e_c, (e_res == 16'h0), e_res});
      acc_q.push_back(cyc);
      acc = cyc;
    end else begin
      checks++; fails++;
      $display("FAIL cmd_accept_timeout: cmd_ready stayed 0, required 1 within 64 cycles");
    end
    @(posedge clk); #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic send_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [TAG_W-1:0] tag, input bit keep, output int acc);
    logic [16:0] r;
    r = alu_ref(op, a, b);
    send(op, a, b, tag, r[15:0], r[16], keep, acc);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_outstanding", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"},  rsp_valid,  0);
    chk({tag, "_cmd_ready"},  cmd_ready,  0);
    chk({tag, "_alu_enable"}, alu_enable, 0);
    chk({tag, "_alu_opnds"},  {alu_op, alu_a, alu_b}, 0);
    chk({tag, "_rsp_fields"}, {rsp_tag, rsp_carry, rsp_zero, rsp_result}, 0);
    chk({tag, "_state"},      dbg_state, ST_IDLE);
  endtask

  // ---------------- monitor ----------------
  int               last_acc = -100;
  bit               prev_valid = 0;
  bit               prev_hs = 0;
  logic [EXP_W-1:0] prev_fields = '0;

  always @(negedge clk) begin
    logic [EXP_W-1:0] act;
    bit exp_en;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      last_acc   = -100;
      prev_valid = 0;
      prev_hs    = 0;
    end else begin
      act = {rsp_tag, rsp_carry, rsp_zero, rsp_result};
      // Enable window: ISSUE, CAPTURE, then HOLD cycles, counted from the accept cycle.
      exp_en = (cyc >= last_acc + 1) && (cyc <= last_acc + 2 + HOLD);
      chk("alu_enable", alu_enable, exp_en);
      if (prev_hs) chk("cmd_ready_after_rsp", cmd_ready, 1);
      if (rsp_valid) begin
        chk("cmd_ready_during_rsp", cmd_ready, 0);
        if (!prev_valid || prev_hs) begin
          if (acc_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_rsp: rsp_valid=1 with tag %0h, required no response", rsp_tag);
          end else begin
            chk("accept_to_rsp_latency", cyc - acc_q.pop_front(), 3);
          end
        end else begin
          chk("rsp_stable_under_bp", act, prev_fields);
        end
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_rsp_hs: got %0h, required no handshake", act);
          end else begin
            chk("rsp_fields", act, exp_q.pop_front());
          end
        end
      end
      if (cmd_valid && cmd_ready) last_acc = cyc;
      prev_valid  = rsp_valid;
      prev_hs     = rsp_valid && rsp_ready;
      prev_fields = act;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int acc, acc1, acc2, acc3, n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("cmd_ready_after_reset", cmd_ready, 1);

    // Directed values from the test plan.
    ready_mode = 1;
    send(OP_ADD, 16'hFFFF, 16'h0001, 4'd3, 16'h0000, 1'b1, 0, acc); wait_drain();
    send(OP_SUB, 16'h0003, 16'h0005, 4'd4, 16'hFFFE, 1'b1, 0, acc); wait_drain();
    send(OP_SHL, 16'h0001, 16'h0013, 4'd5, 16'h0008, 1'b0, 0, acc); wait_drain();
    send(OP_MUL, 16'h0100, 16'h0100, 4'd6, 16'h0000, 1'b0, 0, acc); wait_drain();
    send(OP_MUL, 16'h0012, 16'h0034, 4'd7, 16'h03A8, 1'b0, 0, acc); wait_drain();

    // Response backpressure for 10 cycles.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send(OP_XOR, 16'hA5A5, 16'h0FF0, 4'd8, 16'hAA55, 1'b0, 0, acc);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_rsp_valid_seen", rsp_valid, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_enable_low", alu_enable, 0);
    chk("bp_cmd_ready_low", cmd_ready, 0);
    chk("bp_still_valid", rsp_valid, 1);
    ready_mode = 1;
    wait_drain();

    // Back-to-back with cmd_valid held high.
    send(OP_OR,  16'h1200, 16'h0034, 4'd9,  16'h1234, 1'b0, 1, acc1);
    send(OP_AND, 16'hF0F0, 16'h3C3C, 4'd10, 16'h3030, 1'b0, 1, acc2);
    send(OP_SHR, 16'h8000, 16'h000F, 4'd11, 16'h0001, 1'b0, 0, acc3);
    chk("b2b_spacing_1", acc2 - acc1, 4);
    chk("b2b_spacing_2", acc3 - acc2, 4);
    wait_drain();

    // Reset while in CAPTURE discards the command.
    send(OP_ADD, 16'h0001, 16'h0002, 4'd12, 16'h0003, 1'b0, 0, acc);
    chk("midop_in_issue", dbg_state, ST_ISSUE);
    @(posedge clk); #1;
    chk("midop_in_capture", dbg_state, ST_CAPTURE);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midop_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midop_cmd_ready", cmd_ready, 1);
    chk("midop_no_rsp", rsp_valid, 0);
    send(OP_SUB, 16'h0010, 16'h0001, 4'd13, 16'h000F, 1'b0, 0, acc);
    wait_drain();

    // Randomized traffic against the reference model.
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [15:0] a, b;
      bit          keep;
      op   = 3'($urandom_range(0, 7));
      a    = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
      b    = ($urandom_range(0, 4) == 0) ? a : 16'($urandom);
      keep = ($urandom_range(0, 1) == 1) && (i != 39);
      send_model(op, a, b, 4'(i), keep, acc);
      if (!keep) repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    ready_mode = 1;
    wait_drain();
    repeat (5) @(posedge clk);
    #1;
    chk("final_idle_enable", alu_enable, 0);

    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
